// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter
// Description : Round-robin arbiter and access sequencer sharing one
//               synchronous single-clock block RAM between two requesters
//               (A and B) using a req/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  // Port A
  input  logic              reqA,
  input  logic              weA,
  input  logic [ADDR_W-1:0] addrA,
  input  logic [DATA_W-1:0] wdataA,
  output logic              gntA,
  output logic              ackA,
  output logic [DATA_W-1:0] rdataA,
  // Port B
  input  logic              reqB,
  input  logic              weB,
  input  logic [ADDR_W-1:0] addrB,
  input  logic [DATA_W-1:0] wdataB,
  output logic              gntB,
  output logic              ackB,
  output logic [DATA_W-1:0] rdataB,
  // RAM side
  output logic [ADDR_W-1:0] readAddress,
  output logic [ADDR_W-1:0] writeAddress,
  output logic              writeEnable,
  output logic [DATA_W-1:0] memDataIn,
  input  logic [DATA_W-1:0] memDataOut
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDWAIT = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  state_t              state_q,   state_d;
  logic                sel_b_q,   sel_b_d;   // current owner: 1 = B, 0 = A
  logic                prio_b_q,  prio_b_d;  // 1 = B wins the next tie
  logic                we_q,      we_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  logic [DATA_W-1:0]   wdata_q,   wdata_d;
  logic [DATA_W-1:0]   rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0]   rdata_b_q, rdata_b_d;
  logic                win_b;

  // Next-state logic: arbitration in IDLE, fixed walk through the access states
  always_comb begin
    state_d   = state_q;
    sel_b_d   = sel_b_q;
    prio_b_d  = prio_b_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    // B wins if it is the only requester, or on a tie when A was served last
    win_b     = reqB && (!reqA || prio_b_q);

    case (state_q)
      ST_IDLE: begin
        if (reqA || reqB) begin
          sel_b_d  = win_b;
          prio_b_d = !win_b;
          we_d     = win_b ? weB    : weA;
          addr_d   = win_b ? addrB  : addrA;
          wdata_d  = win_b ? wdataB : wdataA;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_d = we_q ? ST_ACK : ST_RDWAIT;
      end
      ST_RDWAIT: begin
        // RAM output corresponds to the address presented during ACCESS
        if (sel_b_q) begin
          rdata_b_d = memDataOut;
        end else begin
          rdata_a_d = memDataOut;
        end
        state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and data registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      sel_b_q   <= 1'b0;
      prio_b_q  <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_b_q   <= sel_b_d;
      prio_b_q  <= prio_b_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  // Output decode; RAM controls are only non-zero during ACCESS
  always_comb begin
    gntA         = (state_q != ST_IDLE) && !sel_b_q;
    gntB         = (state_q != ST_IDLE) &&  sel_b_q;
    ackA         = (state_q == ST_ACK)  && !sel_b_q;
    ackB         = (state_q == ST_ACK)  &&  sel_b_q;
    writeEnable  = (state_q == ST_ACCESS) && we_q;
    writeAddress = writeEnable ? addr_q  : '0;
    memDataIn    = writeEnable ? wdata_q : '0;
    readAddress  = ((state_q == ST_ACCESS) && !we_q) ? addr_q : '0;
    rdataA       = rdata_a_q;
    rdataB       = rdata_b_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_arbiter
// Description : Self-checking bench for memory_arbiter with a behavioural
//               synchronous RAM and a scoreboard of expected acknowledges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;
  localparam int DW = 16;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          reqA, weA, reqB, weB;
  logic [AW-1:0] addrA, addrB;
  logic [DW-1:0] wdataA, wdataB;
  logic          gntA, ackA, gntB, ackB;
  logic [DW-1:0] rdataA, rdataB;
  logic [AW-1:0] readAddress, writeAddress;
  logic          writeEnable;
  logic [DW-1:0] memDataIn, memDataOut;

  typedef struct packed {
    logic          port_b;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  exp_t          e_mon;
  logic [DW-1:0] mem    [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  logic [DW-1:0] exp_ra = '0;
  logic [DW-1:0] exp_rb = '0;
  int            checks = 0;
  int            errors = 0;

  memory_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .reqA(reqA), .weA(weA), .addrA(addrA), .wdataA(wdataA),
    .gntA(gntA), .ackA(ackA), .rdataA(rdataA),
    .reqB(reqB), .weB(weB), .addrB(addrB), .wdataB(wdataB),
    .gntB(gntB), .ackB(ackB), .rdataB(rdataB),
    .readAddress(readAddress), .writeAddress(writeAddress),
    .writeEnable(writeEnable), .memDataIn(memDataIn), .memDataOut(memDataOut)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous block RAM: one-cycle read latency
  always @(posedge clk) begin
    if (writeEnable) mem[writeAddress] <= memDataIn;
    memDataOut <= mem[readAddress];
  end

  // Scoreboard and invariant monitor, sampled on the falling edge
  always @(negedge clk) begin
    checks++;
    if (gntA === 1'b1 && gntB === 1'b1) begin
      errors++;
      $display("FAIL gnt_exclusive: gntA=%b gntB=%b, required not both 1", gntA, gntB);
    end
    checks++;
    if (writeEnable === 1'b1 && !(gntA === 1'b1 || gntB === 1'b1)) begin
      errors++;
      $display("FAIL we_outside_grant: writeEnable=%b with gntA=%b gntB=%b", writeEnable, gntA, gntB);
    end
    if (ackA === 1'b1 || ackB === 1'b1) begin
      checks++;
      if (ackA === 1'b1 && ackB === 1'b1) begin
        errors++;
        $display("FAIL ack_exclusive: ackA=%b ackB=%b, required one only", ackA, ackB);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: ackA=%b ackB=%b, required no ack", ackA, ackB);
      end else begin
        e_mon = sb.pop_front();
        if (e_mon.port_b !== ackB) begin
          errors++;
          $display("FAIL ack_port: got ackB=%b, required port_b=%b", ackB, e_mon.port_b);
        end else if (ackB === 1'b1) begin
          if (rdataB !== e_mon.data || rdataA !== exp_ra) begin
            errors++;
            $display("FAIL ack_data_b: rdataB=%h rdataA=%h, required %h / %h",
                     rdataB, rdataA, e_mon.data, exp_ra);
          end
          exp_rb = e_mon.data;
        end else begin
          if (rdataA !== e_mon.data || rdataB !== exp_rb) begin
            errors++;
            $display("FAIL ack_data_a: rdataA=%h rdataB=%h, required %h / %h",
                     rdataA, rdataB, e_mon.data, exp_rb);
          end
          exp_ra = e_mon.data;
        end
      end
    end
  end

  // Issue one access, wait for its ack with a cycle budget, then drop req
  task automatic issue(input logic pb, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    exp_t e;
    int   n;
    logic seen;
    @(posedge clk); #1;
    e.port_b = pb;
    if (we) begin
      shadow[a] = d;
      e.data    = pb ? exp_rb : exp_ra;
    end else begin
      e.data    = shadow[a];
    end
    sb.push_back(e);
    if (pb) begin reqB = 1'b1; weB = we; addrB = a; wdataB = d; end
    else    begin reqA = 1'b1; weA = we; addrA = a; wdataA = d; end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = pb ? ackB : ackA;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL issue_timeout: port_b=%b addr=%h got no ack in %0d cycles", pb, a, n);
      if (sb.size() > 0) sb.delete(sb.size() - 1);
    end else if (n != (we ? 3 : 4)) begin
      errors++;
      $display("FAIL issue_latency: port_b=%b we=%b ack after %0d, required %0d", pb, we, n, we ? 3 : 4);
    end
    @(posedge clk); #1;
    if (pb) reqB = 1'b0; else reqA = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    reqA = 0; weA = 0; addrA = '0; wdataA = '0;
    reqB = 0; weB = 0; addrB = '0; wdataB = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    sb.delete();
    exp_ra = '0;
    exp_rb = '0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if ({gntA, gntB, ackA, ackB, writeEnable} !== 5'b0 ||
          {rdataA, rdataB, memDataIn} !== '0 || {readAddress, writeAddress} !== '0) begin
        errors++;
        $display("FAIL reset_idle: gnt=%b%b ack=%b%b we=%b rdA=%h rdB=%h rA=%h wA=%h din=%h, required all 0",
                 gntA, gntB, ackA, ackB, writeEnable, rdataA, rdataB, readAddress, writeAddress, memDataIn);
      end
    end
  endtask

  task automatic test_single_write();
    exp_t e;
    @(posedge clk); #1;
    reqA = 1'b1; weA = 1'b1; addrA = 10'h001; wdataA = 16'h0002;
    shadow[1] = 16'h0002;
    e.port_b = 1'b0; e.data = exp_ra;
    sb.push_back(e);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (writeEnable !== 1'b1 || writeAddress !== 10'h001 || memDataIn !== 16'h0002 ||
        gntA !== 1'b1 || gntB !== 1'b0) begin
      errors++;
      $display("FAIL write_access: we=%b wA=%h din=%h gntA=%b gntB=%b, required 1/001/0002/1/0",
               writeEnable, writeAddress, memDataIn, gntA, gntB);
    end
    @(negedge clk);
    checks++;
    if (ackA !== 1'b1 || writeEnable !== 1'b0 || gntB !== 1'b0) begin
      errors++;
      $display("FAIL write_ack: ackA=%b we=%b gntB=%b, required 1/0/0", ackA, writeEnable, gntB);
    end
    @(posedge clk); #1 reqA = 1'b0;
  endtask

  task automatic test_read_back();
    exp_t e;
    @(posedge clk); #1;
    reqB = 1'b1; weB = 1'b0; addrB = 10'h001;
    e.port_b = 1'b1; e.data = shadow[1];
    sb.push_back(e);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (readAddress !== 10'h001 || writeEnable !== 1'b0 || gntB !== 1'b1 || gntA !== 1'b0) begin
      errors++;
      $display("FAIL read_access: rA=%h we=%b gntB=%b gntA=%b, required 001/0/1/0",
               readAddress, writeEnable, gntB, gntA);
    end
    @(negedge clk);
    checks++;
    if (ackB !== 1'b0 || gntB !== 1'b1) begin
      errors++;
      $display("FAIL read_wait: ackB=%b gntB=%b, required 0/1", ackB, gntB);
    end
    @(negedge clk);
    checks++;
    if (ackB !== 1'b1 || rdataB !== 16'h0002) begin
      errors++;
      $display("FAIL read_ack: ackB=%b rdataB=%h, required 1/0002", ackB, rdataB);
    end
    @(posedge clk); #1 reqB = 1'b0;
  endtask

  task automatic test_contention();
    exp_t       e;
    logic [3:0] ord;
    int         g;
    int         acks;
    int         n;
    logic       prev_busy;
    ord = 4'b1010;  // bit g = 1 means grant g goes to B
    @(posedge clk); #1;
    reset = 1'b0;
    reqA = 1'b1; weA = 1'b1; addrA = 10'd5; wdataA = 16'hA5A5;
    reqB = 1'b1; weB = 1'b1; addrB = 10'd6; wdataB = 16'h5B5B;
    sb.delete();
    exp_ra = '0;
    exp_rb = '0;
    shadow[5] = 16'hA5A5;
    shadow[6] = 16'h5B5B;
    for (int i = 0; i < 4; i++) begin
      e.port_b = ord[i];
      e.data   = '0;
      sb.push_back(e);
    end
    @(posedge clk); #1 reset = 1'b1;
    g = 0; acks = 0; n = 0; prev_busy = 1'b0;
    while (acks < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if ((gntA === 1'b1 || gntB === 1'b1) && !prev_busy) begin
        checks++;
        if (g < 4 && {gntA, gntB} !== (ord[g] ? 2'b01 : 2'b10)) begin
          errors++;
          $display("FAIL grant_order: grant %0d gntA=%b gntB=%b, required port_b=%b", g, gntA, gntB, ord[g]);
        end
        g++;
      end
      prev_busy = (gntA === 1'b1 || gntB === 1'b1);
      if (ackA === 1'b1 || ackB === 1'b1) acks++;
    end
    @(posedge clk); #1;
    reqA = 1'b0;
    reqB = 1'b0;
    checks++;
    if (g != 4 || acks != 4) begin
      errors++;
      $display("FAIL contention_count: grants=%0d acks=%0d, required 4/4", g, acks);
    end
    issue(1'b0, 1'b0, 10'd6, '0);
    issue(1'b1, 1'b0, 10'd5, '0);
  endtask

  task automatic test_input_change();
    exp_t e;
    @(posedge clk); #1;
    reqA = 1'b1; weA = 1'b1; addrA = 10'd3; wdataA = 16'h1234;
    shadow[3] = 16'h1234;
    e.port_b = 1'b0; e.data = exp_ra;
    sb.push_back(e);
    @(posedge clk); #1;
    addrA = 10'd7; wdataA = 16'hFFFF;
    @(negedge clk);
    checks++;
    if (writeEnable !== 1'b1 || writeAddress !== 10'd3 || memDataIn !== 16'h1234) begin
      errors++;
      $display("FAIL latched_inputs: we=%b wA=%h din=%h, required 1/003/1234",
               writeEnable, writeAddress, memDataIn);
    end
    @(negedge clk);
    checks++;
    if (ackA !== 1'b1) begin
      errors++;
      $display("FAIL latched_ack: ackA=%b, required 1", ackA);
    end
    @(posedge clk); #1 reqA = 1'b0;
    issue(1'b0, 1'b0, 10'd3, '0);
    issue(1'b1, 1'b0, 10'd7, '0);
  endtask

  task automatic test_reset_mid_read();
    @(posedge clk); #1;
    reqA = 1'b1; weA = 1'b0; addrA = 10'h001;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (gntA !== 1'b1 || readAddress !== 10'h001) begin
      errors++;
      $display("FAIL midread_access: gntA=%b rA=%h, required 1/001", gntA, readAddress);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    reqA = 1'b0;
    exp_ra = '0;
    exp_rb = '0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (ackA !== 1'b0 || rdataA !== '0 || gntA !== 1'b0) begin
        errors++;
        $display("FAIL midread_abort: ackA=%b rdataA=%h gntA=%b, required 0/0000/0", ackA, rdataA, gntA);
      end
    end
    issue(1'b0, 1'b0, 10'h001, '0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]    = '0;
      shadow[i] = '0;
    end
    test_reset();
    test_single_write();
    test_read_back();
    test_contention();
    test_input_change();
    test_reset_mid_read();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
